// File: rtl/instruction_fetch_queue.sv
// Front-end fetch unit: issues sequential word fetches, buffers the in-order
// responses in a small FIFO and presents the head entry to the decoder.
// Redirects flush the buffer; responses still in flight at a redirect are dropped.
module instruction_fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        n_irdy,
    input  logic        n_stall,
    output logic        fetch_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, FAULT_WAIT} state_t;
    state_t state_reg, state_next;

    // Instruction buffer storage (head is read combinationally for zero-bubble issue)
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic        err_mem  [DEPTH];
    logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg, outstanding_reg;
    logic [DW-1:0] discard_reg;
    logic [31:0]   pc_reg;

    // Addresses of granted, still-unanswered (non-stale) requests, oldest first
    logic [31:0]   req_pc_mem [MAX_OUTSTANDING];
    logic [PW-1:0] req_rd_reg, req_wr_reg;

    logic granted, push, pop, drop;

    function automatic logic [PW-1:0] req_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Request credit check, response classification and head presentation
    always_comb begin
        mem_req = !rst && (state_reg == RUN) && !redirect
                  && (({1'b0, count_reg} + {1'b0, outstanding_reg}) < (CW+1)'(DEPTH))
                  && (outstanding_reg < CW'(MAX_OUTSTANDING));
        mem_addr    = pc_reg;
        granted     = mem_req && mem_gnt;
        push        = mem_rvalid && (discard_reg == '0) && !redirect;
        drop        = mem_rvalid && (discard_reg != '0) && !redirect;
        n_irdy      = (count_reg == '0);
        pop         = !n_irdy && n_stall && !redirect;
        instruction = n_irdy ? NOP   : inst_mem[rd_ptr_reg];
        inst_pc     = n_irdy ? '0    : pc_mem[rd_ptr_reg];
        fetch_fault = n_irdy ? 1'b0  : err_mem[rd_ptr_reg];
    end

    // Buffer payload write: instruction word with the PC of its request
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= mem_rdata;
            pc_mem[wr_ptr_reg]   <= req_pc_mem[req_rd_reg];
            err_mem[wr_ptr_reg]  <= mem_err;
        end
    end

    // Remember the address of every granted request until its response arrives
    always_ff @(posedge clk) begin
        if (granted) begin
            req_pc_mem[req_wr_reg] <= pc_reg;
        end
    end

    // Pointers, occupancy, in-flight accounting and fetch PC
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            req_rd_reg      <= '0;
            req_wr_reg      <= '0;
            pc_reg          <= RESET_PC;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(granted) - CW'(mem_rvalid);
            if (redirect) begin
                // Everything still in flight after this edge is stale, so the
                // discard count becomes the post-edge outstanding count. This also
                // covers back-to-back redirects without counting a request twice.
                rd_ptr_reg  <= '0;
                wr_ptr_reg  <= '0;
                count_reg   <= '0;
                req_rd_reg  <= '0;
                req_wr_reg  <= '0;
                discard_reg <= DW'(outstanding_reg + CW'(granted) - CW'(mem_rvalid));
                pc_reg      <= redirect_pc & ~32'd3;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    req_rd_reg <= req_next(req_rd_reg);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
                if (granted) begin
                    pc_reg     <= pc_reg + 32'd4;
                    req_wr_reg <= req_next(req_wr_reg);
                end
                if (drop) begin
                    discard_reg <= discard_reg - 1'b1;
                end
            end
        end
    end

    // Fetch state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stop fetching after a faulted fetch is buffered; resume only on redirect
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:        if (push && mem_err) state_next = FAULT_WAIT;
            FAULT_WAIT: if (redirect)        state_next = RUN;
            default:    state_next = RUN;
        endcase
    end

    // A response with nothing in flight means the memory broke the protocol
    assert property (@(posedge clk) disable iff (rst) !(mem_rvalid && outstanding_reg == '0));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue: directed scenarios followed by
// randomized traffic, checked every cycle against a queue-based reference model.
module tb_instruction_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, redirect, mem_req, mem_gnt, mem_rvalid, mem_err, n_irdy, n_stall, fetch_fault;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, instruction, inst_pc;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .instruction(instruction), .inst_pc(inst_pc), .n_irdy(n_irdy),
        .n_stall(n_stall), .fetch_fault(fetch_fault)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: requests in flight (tagged stale by a redirect) and buffered entries
    typedef struct { logic [31:0] addr; bit stale; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; bit err; } entry_t;
    flight_t     m_inf[$];
    entry_t      m_buf[$];
    logic [31:0] m_pc;
    bit          m_fault;

    // Memory side: addresses granted by the DUT, answered in order
    logic [31:0] mem_q[$];

    int          gnt_pct, rv_pct, stall_pct;
    bit          redir, err_en;
    logic [31:0] redir_pc, err_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_mem_req"},     32'(mem_req),     32'd0);
        chk({tag, "_n_irdy"},      32'(n_irdy),      32'd1);
        chk({tag, "_instruction"}, instruction,      NOP);
        chk({tag, "_inst_pc"},     inst_pc,          32'd0);
        chk({tag, "_fetch_fault"}, 32'(fetch_fault), 32'd0);
    endtask

    task automatic model_reset();
        m_inf.delete();
        m_buf.delete();
        mem_q.delete();
        m_pc    = 32'h0000_0000;
        m_fault = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs, advance memory and model
    task automatic run_cycle();
        bit      exp_req;
        bit      exp_err;
        entry_t  e;
        flight_t f;
        mem_gnt    = ($urandom_range(99) < gnt_pct);
        mem_rvalid = (mem_q.size() > 0) && ($urandom_range(99) < rv_pct);
        mem_rdata  = $urandom;
        mem_err    = 1'b0;
        if (mem_rvalid) begin
            mem_rdata = mem_word(mem_q[0]);
            mem_err   = err_en && (mem_q[0] == err_addr);
        end
        n_stall     = ($urandom_range(99) >= stall_pct);
        redirect    = redir;
        redirect_pc = redir_pc;
        #2;
        exp_req = !m_fault && !redir && (m_buf.size() + m_inf.size() < DEPTH) && (m_inf.size() < MAXO);
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) chk("mem_addr", mem_addr, m_pc);
        chk("n_irdy", 32'(n_irdy), 32'(m_buf.size() == 0));
        if (m_buf.size() > 0) begin
            chk("instruction", instruction,      m_buf[0].data);
            chk("inst_pc",     inst_pc,          m_buf[0].pc);
            chk("fetch_fault", 32'(fetch_fault), 32'(m_buf[0].err));
        end else begin
            chk("empty_nop", instruction, NOP);
        end
        if (mem_rvalid) void'(mem_q.pop_front());
        if (mem_req && mem_gnt) mem_q.push_back(mem_addr);
        if (m_buf.size() > 0 && n_stall && !redir) begin
            e = m_buf.pop_front();
            $display("t=%0t deliver pc=%h inst=%h fault=%0d", $time, e.pc, e.data, e.err);
        end
        if (mem_rvalid && m_inf.size() > 0) begin
            f = m_inf.pop_front();
            if (!redir && !f.stale) begin
                exp_err = err_en && (f.addr == err_addr);
                m_buf.push_back('{f.addr, mem_word(f.addr), exp_err});
                if (exp_err) m_fault = 1'b1;
            end
        end
        if (exp_req && mem_gnt) begin
            m_inf.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            foreach (m_inf[i]) m_inf[i].stale = 1'b1;
            m_buf.delete();
            m_pc    = redir_pc & ~32'd3;
            m_fault = 1'b0;
        end
        redir = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redir    = 1'b1;
        redir_pc = a;
        run_cycle();
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = '0; mem_err = 1'b0; n_stall = 1'b1;
        gnt_pct = 100; rv_pct = 100; stall_pct = 0;
        redir = 1'b0; redir_pc = '0; err_en = 1'b0; err_addr = '0;
        @(posedge clk); #1;
        reset_check("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // T1: always grant, 1-cycle responses, no stalls
        repeat (12) run_cycle();

        // T2: decoder stalled long enough to fill the buffer, then drain
        stall_pct = 100;
        repeat (10) run_cycle();
        chk("t2_req_dropped", 32'(mem_req), 32'd0);
        chk("t2_head_valid",  32'(n_irdy),  32'd0);
        stall_pct = 0;
        repeat (10) run_cycle();

        // T3: two requests in flight at 0x100/0x104, then redirect to 0x2002
        gnt_pct = 0;
        repeat (4) run_cycle();
        gnt_pct = 100; rv_pct = 0;
        do_redirect(32'h0000_0100);
        repeat (2) run_cycle();
        do_redirect(32'h0000_2002);
        rv_pct = 100;
        repeat (10) run_cycle();

        // T4: faulted fetch at 0x40 stops fetching until redirect to 0x80
        err_en = 1'b1; err_addr = 32'h0000_0040;
        do_redirect(32'h0000_0038);
        repeat (12) run_cycle();
        chk("t4_req_held_off", 32'(mem_req), 32'd0);
        err_en = 1'b0;
        do_redirect(32'h0000_0080);
        repeat (10) run_cycle();

        // T5: fetch address wraps past the top of the address space
        do_redirect(32'hFFFF_FFF8);
        repeat (10) run_cycle();

        // T6: reset with requests in flight and entries queued
        stall_pct = 100; rv_pct = 50;
        repeat (6) run_cycle();
        rst = 1'b1; redirect = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        mem_q.delete();
        @(posedge clk); #1;
        reset_check("t6");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        stall_pct = 0; rv_pct = 100;
        repeat (10) run_cycle();

        // Randomized traffic with random grants, responses, stalls, redirects and faults
        gnt_pct = 70; rv_pct = 60; stall_pct = 30;
        err_en = 1'b1; err_addr = 32'h0000_002C;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 5) begin
                redir    = 1'b1;
                redir_pc = 32'($urandom_range(0, 255));
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
